// File: rtl/fifo_pkg.sv
// Shared FIFO word type and default widths used by the FIFO, its interface
// and the read-side stream adapter.
package fifo_pkg;

   localparam int FIFO_WIDTH_DEFAULT = 16;
   localparam int FIFO_DEPTH_DEFAULT = 16;
   localparam int SKID_DEPTH_DEFAULT = 3;
   localparam int CNT_WIDTH_DEFAULT  = 32;

   typedef logic [FIFO_WIDTH_DEFAULT-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular skid buffer: push at wr_ptr, pop at rd_ptr, occupancy count.
// The caller guarantees no push when full and no pop when empty.
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int W     = FIFO_WIDTH_DEFAULT,
   parameter int DEPTH = SKID_DEPTH_DEFAULT,
   localparam int PW   = $clog2(DEPTH),
   localparam int OW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [OW-1:0] occ
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // pointers wrap at DEPTH, which need not be a power of two
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign head = mem[rd_ptr];

   // pointer/occupancy update; storage is zeroed on reset so head reads 0
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + OW'(1);
            2'b01:   occ <= occ - OW'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the synchronous FIFO: issues rd_en, absorbs the
// one-cycle data_out latency and presents a valid/ready stream from a skid
// buffer. rd_en depends only on registered state, never on m_ready.
// SKID_DEPTH must be at least 2; 3 is needed for one word per cycle.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
   parameter int SKID_DEPTH = SKID_DEPTH_DEFAULT,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  beat_count,
   output logic                  proto_err
);

   localparam int OW = $clog2(SKID_DEPTH + 1);
   localparam logic [OW:0] DEPTH_V = (OW + 1)'(SKID_DEPTH);

   logic [OW-1:0] occ;
   logic          inflight;
   logic [OW:0]   pending;
   logic          pop;

   // an in-flight word already owns a slot, so the buffer cannot overflow
   assign pending    = {1'b0, occ} + {{OW{1'b0}}, inflight};
   assign fifo_rd_en = !rst && !flush && !fifo_empty && (pending < DEPTH_V);

   assign m_valid = (occ != '0);
   assign pop     = m_valid && m_ready;

   fifo_rd_skid #(
      .W     (FIFO_WIDTH),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (inflight),
      .push_data (fifo_data_out),
      .pop       (pop),
      .head      (m_data),
      .occ       (occ)
   );

   // a read issued this cycle returns data next cycle (rd_en is 0 on flush)
   always_ff @(posedge clk) begin
      if (rst) inflight <= 1'b0;
      else     inflight <= fifo_rd_en;
   end

   // handshake counter, wraps naturally; flush leaves it alone
   always_ff @(posedge clk) begin
      if (rst)      beat_count <= '0;
      else if (pop) beat_count <= beat_count + CNT_WIDTH'(1);
   end

   // sticky underflow flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)                 proto_err <= 1'b0;
      else if (fifo_underflow) proto_err <= 1'b1;
   end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter placed directly downstream of the synchronous FIFO. It drives the FIFO's `rd_en`, absorbs the FIFO's one-cycle registered `data_out` latency, and presents the words as a valid/ready stream backed by a small skid buffer. The stream sustains one word per cycle while the FIFO is non-empty and the sink holds `m_ready` high. There is no combinational path from `m_ready` to `fifo_rd_en`.

## Interface
Parameters:
- `FIFO_WIDTH`, default 16: data word width; must match the FIFO.
- `SKID_DEPTH`, default 3: skid buffer entries. Minimum 3 for full throughput; values below 2 are illegal.
- `CNT_WIDTH`, default 32: width of the beat counter.

Ports (name, direction, width, meaning):
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: synchronous discard of buffered and in-flight words.
- `fifo_empty`  in  1: FIFO empty flag (combinational in FIFO).
- `fifo_underflow`  in  1: FIFO underflow flag (registered in FIFO).
- `fifo_data_out`  in  FIFO_WIDTH: FIFO read data, valid one cycle after an accepted read.
- `fifo_rd_en`  out  1: FIFO read enable.
- `m_data`  out  FIFO_WIDTH: stream data (head of skid buffer).
- `m_valid`  out  1: stream valid.
- `m_ready`  in  1: stream ready from sink.
- `beat_count`  out  CNT_WIDTH: number of stream handshakes completed; wraps modulo 2^CNT_WIDTH.
- `proto_err`  out  1: sticky; set when the FIFO reports underflow.

## Operation
- **State:**
  - `occ`: buffer occupancy, 0..SKID_DEPTH.
  - `inflight`: 1 when a read was issued last cycle.
  - Circular buffer with `wr_ptr`/`rd_ptr`, each wrapping at SKID_DEPTH.
- **Issue:** `fifo_rd_en = !rst && !flush && !fifo_empty && (occ + inflight < SKID_DEPTH)`. A read is never issued while the FIFO is empty.
- **Capture:** when `inflight == 1`, `fifo_data_out` is written to `buf[wr_ptr]`, `wr_ptr` advances and `occ` increments.
- **Pop:** `m_valid = (occ != 0)` and `m_data = buf[rd_ptr]`. When `m_valid && m_ready`, `rd_ptr` advances, `occ` decrements and `beat_count` increments.
- **Simultaneous capture and pop:** `occ` is unchanged and both pointers advance.
- **Empty-buffer rule:** capture into an empty buffer becomes visible the next cycle; there is no bypass.
- **Full buffer:** `occ + inflight == SKID_DEPTH` blocks issue. The buffer never overflows, since an in-flight word always has a reserved slot.
- **Sink stall:** `m_valid` and `m_data` hold stable until the handshake completes.
- **Flush:**
  - Sets `occ`, `inflight` and both pointers to 0, and forces `fifo_rd_en = 0` that cycle.
  - A word arriving the cycle after flush (from a read issued the cycle before) is discarded.
  - `beat_count` and `proto_err` are unaffected.
- **Protocol error:** `fifo_underflow == 1` in any cycle sets `proto_err`. It is cleared only by `rst`.
- **Reset (`rst == 1`), at the next edge:**
  - `occ = 0`, `inflight = 0`, pointers = 0.
  - `m_valid = 0`, `m_data = 0`, `beat_count = 0`, `proto_err = 0`.
  - `fifo_rd_en` is 0 combinationally while `rst` is high.
  - Reset mid-stream drops all buffered and in-flight data.

## Timing
- **Latency:** with FIFO non-empty and the buffer empty at cycle 0, `fifo_rd_en = 1` in cycle 0. Data appears on `fifo_data_out` in cycle 1, is captured at the end of cycle 1, and `m_valid = 1` in cycle 2. First-word latency is 2 cycles.
- **Throughput:** steady state is `occ = 1`, `inflight = 1`, with one issue, one capture and one pop per cycle.
- **Sink stall recovery:** with `m_ready` low, the buffer fills to SKID_DEPTH and `fifo_rd_en` drops. When `m_ready` rises, words stream back-to-back without a bubble.
- **Reset:** one cycle of `rst` is sufficient.

## Structure
- **Package `fifo_pkg`:**
  - `typedef logic [FIFO_WIDTH-1:0] fifo_word_t`
  - Default width constants shared with the FIFO and its interface.
- **Sub-module `fifo_rd_skid`:**
  - Contents: circular buffer, pointers and occupancy.
  - Ports: push, `push_data`, pop, `head`, `occ`, clear.
- **Top level:** issue logic, in-flight tracking, counter and error flag.
- **Integration:** connects to the FIFO through the FIFO interface's TEST-side signals (`rd_en` out; `data_out`, `empty`, `underflow` in).

## Test plan
- **Reset:** `rst` held 2 cycles with FIFO non-empty → `fifo_rd_en = 0`, `m_valid = 0`, `m_data = 0`, `beat_count = 0`, `proto_err = 0`.
- **Streaming:**
  - Stimulus: write 0x0001..0x0008 into the FIFO, `m_ready = 1`.
  - Response: `m_valid` rises 2 cycles after the first `fifo_rd_en`. Eight consecutive handshakes in order 0x0001..0x0008 with no gaps. `beat_count = 8`. `fifo_rd_en` never high while `fifo_empty = 1`.
- **Backpressure:**
  - Stimulus: FIFO holds 8 words, `m_ready = 0` for 10 cycles.
  - Response: `occ` reaches 3, `fifo_rd_en` stays low afterwards, `m_data = 0x0001` held stable.
  - Then `m_ready = 1`: 8 words arrive in order back-to-back.
- **Flush:**
  - Stimulus: assert `flush` for 1 cycle while `occ = 2` and `inflight = 1`.
  - Response: `m_valid = 0` the next cycle. The in-flight word is dropped. Streaming resumes with the next FIFO word and no duplicates.
- **Random ready:** randomised `m_ready` with 50% duty over 1000 words from a scoreboard model → output order and count exact, `beat_count = 1000`, `proto_err = 0`.
- **Protocol error:**
  - Stimulus: force `fifo_underflow = 1` for one cycle.
  - Response: `proto_err = 1` and it persists until `rst`. Flush does not clear it.
